// File: rtl/ahbl_i2s_tx_pkg.sv
// Shared constants for the AHB-Lite I2S transmitter: register map, field
// positions, frame geometry and the serializer state type.
package ahbl_i2s_tx_pkg;

  // Word offsets decoded from HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS fields
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_UNDERRUN  = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 8;

  // CTRL fields
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_W   = 8;
  localparam int CTRL_THR_LSB = 16;
  localparam int CTRL_THR_W   = 8;

  // Frame geometry: two 32-bit slots per 64-bit frame
  localparam int FRAME_LEN = 64;
  localparam int SLOT_W    = 32;
  localparam int BITCNT_W  = $clog2(FRAME_LEN);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_e;

  // A new word is loaded at the first falling edge of each slot.
  function automatic logic is_pop_slot(input logic [BITCNT_W-1:0] k);
    return (k == '0) || (k == BITCNT_W'(SLOT_W));
  endfunction

  // Word select is high for k = 31..62: it leads each slot's MSB by one bit.
  function automatic logic ws_for_bit(input logic [BITCNT_W-1:0] k);
    return (k >= BITCNT_W'(SLOT_W - 1)) && (k <= BITCNT_W'(FRAME_LEN - 2));
  endfunction

endpackage

// File: rtl/ahbl_i2s_tx_fifo.sv
// Synchronous show-ahead FIFO holding channel words for the serializer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module i2s_tx_fifo
  import ahbl_i2s_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = SLOT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign pop_ok_o  = pop_i & ~empty_o;
  assign push_ok_o = push_i & (~full_o | pop_ok_o);
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage array: written on accepted pushes only
  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and fill level; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok_o)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok_o, pop_ok_o})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite I2S master transmitter: register file, bit-clock divider and
// Philips-format serializer fed from a channel-word FIFO.
module ahbl_i2s_tx
  import ahbl_i2s_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned DIV_RST    = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        i2s_clk,
  output logic        ws,
  output logic        sd,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bus phase registers
  logic       act_q, wr_q;
  logic [1:0] addr_q;
  logic       wr_en, rd_en;

  // Register file
  logic                  en_q, ie_q;
  logic [CTRL_DIV_W-1:0] div_q;
  logic [CTRL_THR_W-1:0] thr_q;
  logic                  und_q, ovr_q, irq_q;

  // FIFO interface
  logic              push_req, pop_req;
  logic              fifo_push_ok, fifo_pop_ok;
  logic [SLOT_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty;
  logic [7:0]        level8;

  // Serializer state
  tx_state_e             state_q, state_d;
  logic                  run;
  logic [CTRL_DIV_W-1:0] div_cnt_q, div_act_q;
  logic                  tick, fall_tick;
  logic                  clk_q, ws_q, sd_q;
  logic [BITCNT_W-1:0]   bit_q;
  logic [SLOT_W-1:0]     sh_q;
  logic                  underrun_evt, overrun_evt;

  // Address bits below word granularity, upper address and size are not decoded.
  logic unused_bus;
  assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign wr_en     = act_q & wr_q;
  assign rd_en     = act_q & ~wr_q;
  assign level8    = 8'(fifo_level);

  // Capture the address phase of each active transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (HREADY) begin
      act_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  // CTRL register writes in the data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      div_q <= CTRL_DIV_W'(DIV_RST);
      thr_q <= '0;
    end else if (wr_en && (addr_q == REG_CTRL)) begin
      en_q  <= HWDATA[CTRL_EN];
      ie_q  <= HWDATA[CTRL_IE];
      div_q <= HWDATA[CTRL_DIV_LSB +: CTRL_DIV_W];
      thr_q <= HWDATA[CTRL_THR_LSB +: CTRL_THR_W];
    end
  end

  // Sticky error flags: write-1-to-clear, a new event in the same cycle wins
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      und_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en && (addr_q == REG_STATUS) && HWDATA[STAT_UNDERRUN]) und_q <= 1'b0;
      if (wr_en && (addr_q == REG_STATUS) && HWDATA[STAT_OVERRUN])  ovr_q <= 1'b0;
      if (underrun_evt) und_q <= 1'b1;
      if (overrun_evt)  ovr_q <= 1'b1;
    end
  end

  // Registered FIFO-level interrupt
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= ie_q & (level8 <= thr_q);
  end

  // Read mux driven from the registered data-phase address
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (addr_q)
        REG_STATUS: begin
          HRDATA[STAT_FULL]                        = fifo_full;
          HRDATA[STAT_EMPTY]                       = fifo_empty;
          HRDATA[STAT_UNDERRUN]                    = und_q;
          HRDATA[STAT_OVERRUN]                     = ovr_q;
          HRDATA[STAT_LEVEL_LSB +: STAT_LEVEL_W]   = level8;
        end
        REG_CTRL: begin
          HRDATA[CTRL_EN]                          = en_q;
          HRDATA[CTRL_IE]                          = ie_q;
          HRDATA[CTRL_DIV_LSB +: CTRL_DIV_W]       = div_q;
          HRDATA[CTRL_THR_LSB +: CTRL_THR_W]       = thr_q;
        end
        default: HRDATA = '0;
      endcase
    end
  end

  assign push_req     = wr_en & (addr_q == REG_DATA);
  assign overrun_evt  = push_req & ~fifo_push_ok;
  assign pop_req      = fall_tick & is_pop_slot(bit_q);
  assign underrun_evt = pop_req & fifo_empty;

  i2s_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SLOT_W)
  ) u_fifo (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .push_i    (push_req),
    .wdata_i   (HWDATA),
    .pop_i     (pop_req),
    .rdata_o   (fifo_rdata),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .push_ok_o (fifo_push_ok),
    .pop_ok_o  (fifo_pop_ok)
  );

  // Transmitter state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= TX_IDLE;
    else          state_q <= state_d;
  end

  // Next state: follow EN; run is dropped as soon as EN clears so an abort
  // reaches the pins on the very next clock
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (en_q)  state_d = TX_RUN;
      TX_RUN:  if (!en_q) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  assign run       = (state_q == TX_RUN) & en_q;
  assign tick      = run & (div_cnt_q == div_act_q);
  assign fall_tick = tick & clk_q;

  // Divider: the active divisor is reloaded only at ticks so DIV changes land cleanly
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt_q <= '0;
      div_act_q <= CTRL_DIV_W'(DIV_RST);
    end else if (!run || tick) begin
      div_cnt_q <= '0;
      div_act_q <= div_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Serializer: sd and ws update together with each falling bit-clock edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clk_q <= 1'b0;
      ws_q  <= 1'b0;
      sd_q  <= 1'b0;
      bit_q <= '0;
      sh_q  <= '0;
    end else if (!run) begin
      clk_q <= 1'b0;
      ws_q  <= 1'b0;
      sd_q  <= 1'b0;
      bit_q <= '0;
      sh_q  <= '0;
    end else if (tick) begin
      clk_q <= ~clk_q;
      if (clk_q) begin
        bit_q <= bit_q + 1'b1;
        ws_q  <= ws_for_bit(bit_q);
        if (is_pop_slot(bit_q)) begin
          if (fifo_pop_ok) begin
            sd_q <= fifo_rdata[SLOT_W-1];
            sh_q <= {fifo_rdata[SLOT_W-2:0], 1'b0};
          end else begin
            sd_q <= 1'b0;
            sh_q <= '0;
          end
        end else begin
          sd_q <= sh_q[SLOT_W-1];
          sh_q <= {sh_q[SLOT_W-2:0], 1'b0};
        end
      end
    end
  end

  assign i2s_clk = clk_q;
  assign ws      = ws_q;
  assign sd      = sd_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        i2s_clk, ws, sd, irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rise = 0;

  ahbl_i2s_tx #(.FIFO_DEPTH(8), .DIV_RST(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .i2s_clk(i2s_clk), .ws(ws), .sd(sd), .irq(irq)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic next_rise(output bit ok);
    logic prev;
    prev = i2s_clk;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(posedge HCLK); #1;
      if (!prev && i2s_clk) begin
        ok = 1'b1;
        break;
      end
      prev = i2s_clk;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL rise_timeout: no i2s_clk rising edge within 64 cycles");
    end
  endtask

  // Sample one 32-bit slot, MSB first, at the rising edges of i2s_clk.
  task automatic capture_word(input int per, output logic [31:0] sdw,
                              output logic [31:0] wsw, output int per_bad);
    bit ok;
    per_bad = 0;
    for (int i = 31; i >= 0; i--) begin
      next_rise(ok);
      sdw[i] = sd;
      wsw[i] = ws;
      if (cyc - last_rise != per) per_bad++;
      last_rise = cyc;
    end
  endtask

  initial begin
    logic [31:0] rd, w, wsw;
    int          pb, nfall, fall_cyc, irq_cyc, nz;
    bit          ok;
    logic        prev;
    logic [31:0] pushed [9];

    vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h0000_0002, 1'b0};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'h0000_0300, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 4'h8, 32'h00AB_1202, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        32'h00AB_1202, 1'b1};
    vecs[8]  = '{1'b1, 4'h8, 32'h0000_0002, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 4'h0, 32'h8000_0001, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 4'h4, 32'h0,        32'h0000_0100, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0003, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 4'h4, 32'h0,        32'h0000_0200, 1'b0};
    vecs[13] = '{1'b1, 4'h8, 32'h0000_0000, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 4'h8, 32'h0,        32'h0000_0000, 1'b0};

    // Reset and idle outputs
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_outputs", {60'h0, i2s_clk, ws, sd, irq}, 64'h0);
    check("hreadyout", {63'h0, HREADYOUT}, 64'h1);
    HRESETn = 1'b1;
    nz = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge HCLK); #1;
      if (i2s_clk || ws || sd || irq) nz++;
    end
    check("idle_100_cycles_nonzero", 64'(nz), 64'h0);

    // Register-access vector table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        ahb_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        ahb_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, vecs[i].exp_rd});
      end
      @(posedge HCLK); #1;
      check($sformatf("vec%0d_irq", i), {63'h0, irq}, {63'h0, vecs[i].exp_irq});
    end

    // DIV=0 frame with 0x80000001 / 0x00000003 already queued
    ahb_write(4'h8, 32'h0000_0001);
    next_rise(ok);
    last_rise = cyc;
    capture_word(2, w, wsw, pb);
    check("div0_left_sd", {32'h0, w}, 64'h8000_0001);
    check("div0_left_ws", {32'h0, wsw}, 64'h0000_0001);
    check("div0_left_period_bad", 64'(pb), 64'h0);
    capture_word(2, w, wsw, pb);
    check("div0_right_sd", {32'h0, w}, 64'h0000_0003);
    check("div0_right_ws", {32'h0, wsw}, 64'hFFFF_FFFE);
    check("div0_right_period_bad", 64'(pb), 64'h0);

    // Next frame underruns
    capture_word(2, w, wsw, pb);
    check("underrun_left_sd", {32'h0, w}, 64'h0);
    capture_word(2, w, wsw, pb);
    check("underrun_right_sd", {32'h0, w}, 64'h0);
    check("underrun_right_ws", {32'h0, wsw}, 64'hFFFF_FFFE);
    ahb_write(4'h8, 32'h0000_0000);
    ahb_read(4'h4, rd);
    check("status_underrun", {32'h0, rd}, 64'h0000_0006);
    ahb_write(4'h4, 32'h0000_0004);
    ahb_read(4'h4, rd);
    check("status_underrun_cleared", {32'h0, rd}, 64'h0000_0002);

    // Overrun: nine pushes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      pushed[i] = 32'hC0DE_0000 | 32'(i + 1);
      ahb_write(4'h0, pushed[i]);
    end
    ahb_read(4'h4, rd);
    check("status_overrun_full", {32'h0, rd}, 64'h0000_0809);
    ahb_write(4'h8, 32'h0000_0101);
    next_rise(ok);
    last_rise = cyc;
    for (int i = 0; i < 8; i++) begin
      capture_word(4, w, wsw, pb);
      check($sformatf("ovr_word%0d", i), {32'h0, w}, {32'h0, pushed[i]});
      check($sformatf("ovr_word%0d_period_bad", i), 64'(pb), 64'h0);
    end
    capture_word(4, w, wsw, pb);
    check("ninth_not_sent_left", {32'h0, w}, 64'h0);
    capture_word(4, w, wsw, pb);
    check("ninth_not_sent_right", {32'h0, w}, 64'h0);
    ahb_write(4'h8, 32'h0000_0000);
    ahb_read(4'h4, rd);
    check("status_both_sticky", {32'h0, rd}, 64'h0000_000E);
    ahb_write(4'h4, 32'h0000_0008);
    ahb_read(4'h4, rd);
    check("status_overrun_cleared_only", {32'h0, rd}, 64'h0000_0006);
    ahb_write(4'h4, 32'h0000_0004);
    ahb_read(4'h4, rd);
    check("status_all_clear", {32'h0, rd}, 64'h0000_0002);

    // irq threshold: THR=2, IE=1, four words queued
    ahb_write(4'h0, 32'h0F0F_0F0F);
    ahb_write(4'h0, 32'hFFFF_FFFF);
    ahb_write(4'h0, 32'hFFFF_FFFF);
    ahb_write(4'h0, 32'hFFFF_FFFF);
    ahb_write(4'h8, 32'h0002_0002);
    @(posedge HCLK); #1;
    check("irq_low_level4", {63'h0, irq}, 64'h0);
    ahb_write(4'h8, 32'h0002_0003);
    nfall = 0; fall_cyc = -1; irq_cyc = -1; prev = i2s_clk;
    for (int n = 0; n < 400 && nfall < 41; n++) begin
      @(posedge HCLK); #1;
      if (prev && !i2s_clk) begin
        if (nfall == 32) fall_cyc = cyc;
        nfall++;
      end
      if (irq && irq_cyc < 0) irq_cyc = cyc;
      prev = i2s_clk;
    end
    check("irq_falls_seen", 64'(nfall), 64'd41);
    check("irq_rise_cycle", 64'(irq_cyc), 64'(fall_cyc + 1));
    check("k40_ws_sd", {62'h0, ws, sd}, 64'h3);

    // Abort by clearing EN at k=40
    ahb_write(4'h8, 32'h0000_0000);
    @(posedge HCLK); #1;
    check("abort_outputs", {61'h0, i2s_clk, ws, sd}, 64'h0);
    nz = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge HCLK); #1;
      if (i2s_clk || ws || sd) nz++;
    end
    check("abort_held_nonzero", 64'(nz), 64'h0);

    // Asynchronous reset mid-frame
    ahb_write(4'h8, 32'h0000_0001);
    nfall = 0; prev = i2s_clk;
    for (int n = 0; n < 400 && nfall < 41; n++) begin
      @(posedge HCLK); #1;
      if (prev && !i2s_clk) nfall++;
      prev = i2s_clk;
    end
    check("rst_falls_seen", 64'(nfall), 64'd41);
    check("rst_k40_ws_sd", {62'h0, ws, sd}, 64'h3);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_reset_outputs", {60'h0, i2s_clk, ws, sd, irq}, 64'h0);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(4'h4, rd);
    check("status_after_reset", {32'h0, rd}, 64'h0000_0002);
    ahb_read(4'h8, rd);
    check("ctrl_after_reset", {32'h0, rd}, 64'h0000_0300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
